// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution unit: control codes and the buffered entry record.
package alu_exec_pkg;

  localparam int ALU_CTL_W = 2;

  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_CTL_W-1:0] ALU_AND = 2'b01;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 2'b10;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 2'b11;

  localparam int ALU_DEF_W = 32;

  // Entry record at the default datapath width; the unit rebuilds it at its own WIDTH.
  typedef struct packed {
    logic [ALU_DEF_W-1:0] result;
    logic                 zero;
    logic                 ovf;
  } alu_entry_t;

endpackage

// File: rtl/alu_exec_if.sv
// Valid/ready operation and result bus of the ALU execution unit.
interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_CTL_W-1:0] in_ctl;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_zero;
  logic                 out_ovf;
  logic [CNT_W-1:0]     op_count;

  modport master (
    output in_valid, in_ctl, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, op_count
  );

  modport slave (
    input  in_valid, in_ctl, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, op_count
  );

endinterface

// File: rtl/alu_exec_fifo2.sv
// Generic 2-entry valid/ready buffer with registered head; head holds its last value when empty.
module alu_exec_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data
);

  logic [1:0]    count_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic          push;
  logic          pop;

  // Ready depends only on the registered count, never on pop_ready.
  assign push_ready = (count_q != 2'd2);
  assign pop_valid  = (count_q != 2'd0);
  assign pop_data   = head_q;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Simultaneous push/pop only happens at count 1: new entry replaces the head.
        2'b11: head_q <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: add/and/or/sub with zero flag, 2-entry result buffer and saturating op counter.
// Define ALU_EXEC_OVF_EN to compute and store the signed overflow flag; otherwise out_ovf is tied 0.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_exec_if.slave   bus
);

`ifdef ALU_EXEC_OVF_EN
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
  } entry_t;
`else
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
  } entry_t;
`endif

  localparam int ENTRY_W = $bits(entry_t);

  entry_t           new_e;
  entry_t           head_e;
  logic [WIDTH-1:0] res;
  logic             fifo_valid;
  logic             fifo_ready;
  logic [CNT_W-1:0] op_count_q;

  always_comb begin
    res = '0;
    case (bus.in_ctl)
      ALU_ADD: res = bus.in_a + bus.in_b;
      ALU_AND: res = bus.in_a & bus.in_b;
      ALU_OR:  res = bus.in_a | bus.in_b;
      ALU_SUB: res = bus.in_a - bus.in_b;
      default: res = '0;
    endcase
  end

  always_comb begin
    new_e        = '0;
    new_e.result = res;
    new_e.zero   = (res == '0);
`ifdef ALU_EXEC_OVF_EN
    case (bus.in_ctl)
      ALU_ADD: new_e.ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                           (res[WIDTH-1] != bus.in_a[WIDTH-1]);
      ALU_SUB: new_e.ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                           (res[WIDTH-1] != bus.in_a[WIDTH-1]);
      default: new_e.ovf = 1'b0;
    endcase
`endif
  end

  alu_exec_fifo2 #(.DW(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.in_valid),
    .push_ready (fifo_ready),
    .push_data  (new_e),
    .pop_valid  (fifo_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head_e)
  );

  assign bus.in_ready   = fifo_ready;
  assign bus.out_valid  = fifo_valid;
  assign bus.out_result = head_e.result;
  assign bus.out_zero   = head_e.zero;
`ifdef ALU_EXEC_OVF_EN
  assign bus.out_ovf    = head_e.ovf;
`else
  assign bus.out_ovf    = 1'b0;
`endif
  assign bus.op_count   = op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (fifo_valid && bus.out_ready && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a result scoreboard; a second instance checks counter saturation.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

`ifdef ALU_EXEC_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  alu_exec_if #(.WIDTH(32), .CNT_W(16)) bus0 ();
  alu_exec_if #(.WIDTH(32), .CNT_W(2))  bus1 ();

  alu_exec_unit #(.WIDTH(32), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_exec_unit #(.WIDTH(32), .CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         n_pop = 0;
  bit         acc = 0;
  bit         hold_pending = 0;
  alu_entry_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic alu_entry_t model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_entry_t e;
    logic [31:0] r;
    logic o;
    o = 1'b0;
    case (c)
      ALU_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
    endcase
    e.result = r;
    e.zero   = (r == 32'd0);
    e.ovf    = OVF_ON ? o : 1'b0;
    return e;
  endfunction

  // Called just after a falling edge with inputs set: evaluates the coming rising edge's handshakes.
  task automatic tick();
    alu_entry_t e;
    acc = 0;
    if (rst_n) begin
      if (hold_pending) check("hold_valid", 64'(bus0.in_valid), 64'd1);
      if (bus0.out_valid && bus0.out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          check("result", 64'({bus0.out_result, bus0.out_zero, bus0.out_ovf}), 64'(e));
          n_pop++;
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        sb.push_back(model(bus0.in_ctl, bus0.in_a, bus0.in_b));
        acc = 1;
      end
      hold_pending = bus0.in_valid && !bus0.in_ready;
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    bus0.in_valid = 1'b1;
    bus0.in_ctl   = c;
    bus0.in_a     = a;
    bus0.in_b     = b;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    if (!acc) check("offer_timeout", 64'(acc), 64'd1);
    bus0.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic z, input logic o);
    offer(c, a, b);
    check({tag, "_lat"},  64'(bus0.out_valid), 64'd1);
    check({tag, "_res"},  64'(bus0.out_result), 64'(r));
    check({tag, "_zero"}, 64'(bus0.out_zero), 64'(z));
    check({tag, "_ovf"},  64'(bus0.out_ovf), 64'(o));
    tick();
    check({tag, "_drain"}, 64'(bus0.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    rst_n          = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_ctl    = ALU_ADD;
    bus0.in_a      = 32'd1;
    bus0.in_b      = 32'd1;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_ctl    = ALU_ADD;
    bus1.in_a      = 32'd0;
    bus1.in_b      = 32'd0;
    bus1.out_ready = 1'b1;

    // Reset behaviour
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_op_count",  64'(bus0.op_count), 64'd0);
    check("rst_in_ready",  64'(bus0.in_ready), 64'd1);
    check("rst_result",    64'(bus0.out_result), 64'd0);
    bus0.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready",  64'(bus0.in_ready), 64'd1);
    check("rel_out_valid", 64'(bus0.out_valid), 64'd0);

    // Single ops, unstalled
    directed("add", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, OVF_ON);
    directed("sub", ALU_SUB, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b0);
    directed("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
    directed("or",  ALU_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    directed("subv", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, OVF_ON);
    check("cnt_after_ops", 64'(bus0.op_count), 64'd5);

    // Backpressure: two accepted, third waits
    bus0.out_ready = 1'b0;
    offer(ALU_ADD, 32'd1, 32'd1);
    offer(ALU_ADD, 32'd2, 32'd2);
    check("bp_full_ready", 64'(bus0.in_ready), 64'd0);
    bus0.in_valid = 1'b1;
    bus0.in_a     = 32'd3;
    bus0.in_b     = 32'd3;
    tick();
    tick();
    check("bp_hold_valid", 64'(bus0.out_valid), 64'd1);
    check("bp_hold_head",  64'(bus0.out_result), 64'd2);
    check("bp_hold_ready", 64'(bus0.in_ready), 64'd0);
    bus0.out_ready = 1'b1;
    tick();
    check("bp_pop_frees", 64'(bus0.in_ready), 64'd1);
    tick();
    check("bp_accept", 64'(acc), 64'd1);
    bus0.in_valid = 1'b0;
    tick();
    check("bp_empty",   64'(bus0.out_valid), 64'd0);
    check("bp_count",   64'(bus0.op_count), 64'd8);
    check("bp_sb_size", 64'(sb.size()), 64'd0);

    // Reset with two entries buffered
    bus0.out_ready = 1'b0;
    offer(ALU_ADD, 32'd10, 32'd20);
    offer(ALU_OR, 32'd1, 32'd2);
    check("pre_rst_ready", 64'(bus0.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus0.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus0.in_ready), 64'd1);
    check("mid_rst_count", 64'(bus0.op_count), 64'd0);
    sb.delete();
    hold_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;

    // Throughput: 8 back-to-back ops
    pop0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_ctl   = 2'(i);
      bus0.in_a     = 32'h1234_0000 + 32'(i * 7);
      bus0.in_b     = 32'h0000_1111 * 32'(i + 1);
      tick();
      check("tp_accept", 64'(acc), 64'd1);
      check("tp_valid",  64'(bus0.out_valid), 64'd1);
    end
    bus0.in_valid = 1'b0;
    tick();
    check("tp_empty", 64'(bus0.out_valid), 64'd0);
    check("tp_pops",  64'(n_pop - pop0), 64'd8);
    check("tp_count", 64'(bus0.op_count), 64'd8);
    check("tp_sb",    64'(sb.size()), 64'd0);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_a     = 32'(i);
      bus1.in_b     = 32'd1;
      check("sat_ready", 64'(bus1.in_ready), 64'd1);
      @(negedge clk);
      if (i == 2) check("sat_mid", 64'(bus1.op_count), 64'd2);
    end
    bus1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_count", 64'(bus1.op_count), 64'd3);
    check("sat_empty", 64'(bus1.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
